// File: rtl/legv8_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port LEGv8 data RAM.
// Each granted access runs IDLE -> ACCESS -> DONE, one cycle per state.
module legv8_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_writeEn,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    logic   any_req;
    logic   pick;
    logic   we_q;

    assign any_req = p0_req | p1_req;
    // On a tie the port that did not win last time goes next.
    assign pick = (p0_req & p1_req) ? ~last_grant : p1_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = IDLE;
        unique case (state)
            IDLE:    state_nx = any_req ? ACCESS : IDLE;
            ACCESS:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        ram_writeEn = 1'b0;
        p0_ack      = 1'b0;
        p1_ack      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            ACCESS: begin
                busy        = 1'b1;
                ram_writeEn = we_q;
            end
            DONE: begin
                busy   = 1'b1;
                p0_ack = ~last_grant;
                p1_ack = last_grant;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // last_grant doubles as the owner of the transaction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_address <= '0;
            ram_in      <= '0;
            we_q        <= 1'b0;
            last_grant  <= 1'b1;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                ram_address <= pick ? p1_addr : p0_addr;
                ram_in      <= pick ? p1_wdata : p0_wdata;
                we_q        <= pick ? p1_we : p0_we;
                last_grant  <= pick;
            end
            if (state == ACCESS && !we_q) begin
                if (last_grant) begin
                    p1_rdata <= ram_out;
                end else begin
                    p0_rdata <= ram_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_legv8_mem_arbiter.sv
// Scoreboard bench for legv8_mem_arbiter with a behavioural RAM.
// Directed transactions push expectations; an ack monitor pops and checks.
module tb_legv8_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req = 1'b0;
    logic        p0_we = 1'b0;
    logic [7:0]  p0_addr = '0;
    logic [63:0] p0_wdata = '0;
    logic        p0_ack;
    logic [63:0] p0_rdata;
    logic        p1_req = 1'b0;
    logic        p1_we = 1'b0;
    logic [7:0]  p1_addr = '0;
    logic [63:0] p1_wdata = '0;
    logic        p1_ack;
    logic [63:0] p1_rdata;
    logic [7:0]  ram_address;
    logic [63:0] ram_in;
    logic        ram_writeEn;
    logic [63:0] ram_out;
    logic        busy;
    logic        last_grant;

    logic [63:0] mem [256] = '{default: '0};

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   fails = 0;
    int   we_cnt = 0;

    legv8_mem_arbiter #(.ADDR_W(8), .DATA_W(64)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .p0_req(p0_req),
        .p0_we(p0_we),
        .p0_addr(p0_addr),
        .p0_wdata(p0_wdata),
        .p0_ack(p0_ack),
        .p0_rdata(p0_rdata),
        .p1_req(p1_req),
        .p1_we(p1_we),
        .p1_addr(p1_addr),
        .p1_wdata(p1_wdata),
        .p1_ack(p1_ack),
        .p1_rdata(p1_rdata),
        .ram_address(ram_address),
        .ram_in(ram_in),
        .ram_writeEn(ram_writeEn),
        .ram_out(ram_out),
        .busy(busy),
        .last_grant(last_grant)
    );

    always #5 clock = ~clock;

    assign ram_out = mem[ram_address];

    always @(posedge clock) begin
        if (ram_writeEn) mem[ram_address] <= ram_in;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Ack monitor: every ack must match the next queued expectation.
    always @(negedge clock) begin
        if (ram_writeEn) we_cnt++;
        if (reset_n && (p0_ack || p1_ack)) begin
            check("single_ack", {63'd0, p0_ack & p1_ack}, 64'd0);
            if (q.size() == 0) begin
                check("unexpected_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
            end else begin
                automatic exp_t e = q.pop_front();
                check("ack_port", {63'd0, p1_ack}, {63'd0, e.port});
                check("last_grant", {63'd0, last_grant}, {63'd0, e.port});
                if (e.we)
                    check("mem_write", mem[e.addr], e.data);
                else if (e.port)
                    check("p1_rdata", p1_rdata, e.data);
                else
                    check("p0_rdata", p0_rdata, e.data);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_we"}, {63'd0, ram_writeEn}, 64'd0);
        check({tag, "_acks"}, {62'd0, p1_ack, p0_ack}, 64'd0);
        check({tag, "_addr"}, {56'd0, ram_address}, 64'd0);
        check({tag, "_ram_in"}, ram_in, 64'd0);
        check({tag, "_p0_rdata"}, p0_rdata, 64'd0);
        check({tag, "_p1_rdata"}, p1_rdata, 64'd0);
        check({tag, "_last_grant"}, {63'd0, last_grant}, 64'd1);
    endtask

    // Called at posedge+1 with the arbiter idle; returns there after ack.
    task automatic txn(input bit port, input bit we, input logic [7:0] addr,
                       input logic [63:0] wdata, input logic [63:0] expd);
        int n = 0;
        bit got = 0;
        int w0 = we_cnt;
        q.push_back('{port, we, addr, expd});
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            got = port ? p1_ack : p0_ack;
        end
        check("ack_latency", 64'(n), 64'd3);
        @(posedge clock); #1;
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
        check("we_cycles", 64'(we_cnt - w0), {63'd0, we});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        int c1;
        int t0;
        int t1;
        #12;
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(posedge clock); #1;

        txn(0, 1, 8'd3, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
        txn(0, 0, 8'd3, 64'd0, 64'hDEAD_BEEF);
        txn(1, 1, 8'd255, 64'hFFFF_0000_1234_5678, 64'hFFFF_0000_1234_5678);
        txn(1, 0, 8'd255, 64'd0, 64'hFFFF_0000_1234_5678);
        txn(0, 1, 8'd0, 64'h0123, 64'h0123);
        txn(1, 0, 8'd0, 64'd0, 64'h0123);
        txn(0, 1, 8'd7, 64'h7777, 64'h7777);
        txn(1, 1, 8'd4, 64'h4444, 64'h4444);

        // Inputs moved after the grant must not reach the RAM.
        q.push_back('{1'b1, 1'b0, 8'd7, 64'h7777});
        p1_we = 1'b0; p1_addr = 8'd7; p1_req = 1'b1;
        @(posedge clock); #1;
        p1_addr = 8'd9; p1_we = 1'b1;
        #1 check("addr_hold_access", {56'd0, ram_address}, 64'd7);
        check("we_hold_access", {63'd0, ram_writeEn}, 64'd0);
        n = 0;
        while (!p1_ack && n < 10) begin @(negedge clock); n++; end
        check("addr_hold_done", {56'd0, ram_address}, 64'd7);
        check("addr9_untouched", mem[9], 64'd0);
        @(posedge clock); #1;
        p1_req = 1'b0;

        // Reset while in ACCESS cancels the write and the ack.
        p0_we = 1'b1; p0_addr = 8'd4; p0_wdata = 64'd5; p0_req = 1'b1;
        @(posedge clock); #1;
        check("we_before_reset", {63'd0, ram_writeEn}, 64'd1);
        reset_n = 1'b0;
        #1 check_reset_vals("midrst");
        p0_req = 1'b0;
        @(posedge clock); #1;
        check("mem4_unchanged", mem[4], 64'h4444);
        reset_n = 1'b1;
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (p0_ack || p1_ack || busy) c0++;
        end
        check("post_reset_quiet", 64'(c0), 64'd0);
        @(posedge clock); #1;

        // Tie right after reset: port 0 first, port 1 three cycles later.
        q.push_back('{1'b0, 1'b1, 8'd20, 64'h20});
        q.push_back('{1'b1, 1'b0, 8'd20, 64'h20});
        p0_we = 1'b1; p0_addr = 8'd20; p0_wdata = 64'h20; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 8'd20; p1_req = 1'b1;
        n = 0; t0 = 0; t1 = 0;
        while ((t0 == 0 || t1 == 0) && n < 30) begin
            @(negedge clock);
            n++;
            if (p0_ack) begin t0 = n; p0_req = 1'b0; end
            if (p1_ack) begin t1 = n; p1_req = 1'b0; end
        end
        check("tie_p0_ack", 64'(t0), 64'd3);
        check("tie_p1_ack", 64'(t1), 64'd6);
        @(posedge clock); #1;

        // Sustained contention: four grants each, strictly alternating.
        for (int k = 0; k < 4; k++) begin
            q.push_back('{1'b0, 1'b1, 8'd10, 64'(100 + k)});
            q.push_back('{1'b1, 1'b0, 8'd10, 64'(100 + k)});
        end
        p0_we = 1'b1; p0_addr = 8'd10; p0_wdata = 64'd100; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 8'd10; p1_req = 1'b1;
        n = 0; c0 = 0; c1 = 0;
        while ((c0 < 4 || c1 < 4) && n < 100) begin
            @(negedge clock);
            n++;
            if (p0_ack) begin
                c0++;
                p0_wdata = 64'(100 + c0);
                if (c0 == 4) p0_req = 1'b0;
            end
            if (p1_ack) begin
                c1++;
                if (c1 == 4) p1_req = 1'b0;
            end
        end
        check("contention_cycles", 64'(n), 64'd24);
        check("contention_p0", 64'(c0), 64'd4);
        check("contention_p1", 64'(c1), 64'd4);
        @(posedge clock); #1;

        // A request pulsed between edges is never sampled.
        #2 p1_req = 1'b1;
        #2 p1_req = 1'b0;
        c0 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (busy || p1_ack) c0++;
        end
        check("withdrawn_idle", 64'(c0), 64'd0);

        @(negedge clock);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
